inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 105 ++++++++++
 tb/tb_inst_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of {inst, pc} entries with head/tail pointers and an
// occupancy count. Head entry is presented combinationally from registered
// state; a new entry becomes visible the cycle after it is written.
// IQ_DEPTH must be a power of two and at least 4.
module inst_queue #(
   parameter int unsigned IQ_DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        IF_inst_valid,
   input  logic [31:0] IF_inst,
   input  logic [31:0] IF_pc,
   output logic        IF_queue_is_full,
   input  logic        ID_ready,
   output logic        ID_inst_valid,
   output logic [31:0] ID_inst,
   output logic [31:0] ID_pc,
   input  logic        ROB_clear
);

   localparam int unsigned PTR_W  = $clog2(IQ_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WORD_W = 32;

   typedef struct packed {
      logic [WORD_W-1:0] inst;
      logic [WORD_W-1:0] pc;
   } iq_entry_t;

   iq_entry_t          mem [IQ_DEPTH];
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               empty_c;
   logic               pop_c;
   logic               push_c;
   iq_entry_t          head_entry_c;

   // Handshake qualification; a push into a full queue is only legal when
   // the head leaves on the same edge, so the write lands in the freed slot.
   always_comb begin
      empty_c = (count_q == '0);
      pop_c   = rdy && !ROB_clear && !empty_c && ID_ready;
      push_c  = rdy && !ROB_clear && IF_inst_valid &&
                ((count_q < CNT_W'(IQ_DEPTH)) || pop_c);
   end

   // Next-state for pointers and count; flush wins over any push/pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rdy) begin
         if (ROB_clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
         end else begin
            if (pop_c) begin
               head_d = head_q + PTR_W'(1);
            end
            if (push_c) begin
               tail_d = tail_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
               count_d = count_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
               count_d = count_q - CNT_W'(1);
            end
         end
      end
   end

   // Pointer and count registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[tail_q] <= iq_entry_t'({IF_inst, IF_pc});
      end
   end

   // Head presentation and back-pressure, zeroed when the queue is empty.
   always_comb begin
      head_entry_c     = mem[head_q];
      ID_inst_valid    = !empty_c;
      ID_inst          = empty_c ? '0 : head_entry_c.inst;
      ID_pc            = empty_c ? '0 : head_entry_c.pc;
      IF_queue_is_full = (count_q >= CNT_W'(IQ_DEPTH - 2));
   end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_queue;

   localparam int unsigned D = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        IF_inst_valid;
   logic [31:0] IF_inst;
   logic [31:0] IF_pc;
   logic        IF_queue_is_full;
   logic        ID_ready;
   logic        ID_inst_valid;
   logic [31:0] ID_inst;
   logic [31:0] ID_pc;
   logic        ROB_clear;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] mq[$];        // reference model: {inst, pc}, front = head
   logic [31:0] popped[$];    // pcs seen leaving the DUT

   inst_queue #(.IQ_DEPTH(D)) dut (
      .clk              (clk),
      .rst              (rst),
      .rdy              (rdy),
      .IF_inst_valid    (IF_inst_valid),
      .IF_inst          (IF_inst),
      .IF_pc            (IF_pc),
      .IF_queue_is_full (IF_queue_is_full),
      .ID_ready         (ID_ready),
      .ID_inst_valid    (ID_inst_valid),
      .ID_inst          (ID_inst),
      .ID_pc            (ID_pc),
      .ROB_clear        (ROB_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, apply the queue rules to the model, sample at edge+1.
   task automatic drive_edge(input logic r, input logic v, input logic [31:0] inst,
                             input logic [31:0] pc, input logic rd, input logic cl);
      bit do_pop;
      bit do_push;
      rdy = r; IF_inst_valid = v; IF_inst = inst; IF_pc = pc;
      ID_ready = rd; ROB_clear = cl;
      #1;
      if (r && !cl && rd && ID_inst_valid) popped.push_back(ID_pc);
      @(posedge clk);
      if (r) begin
         if (cl) begin
            mq.delete();
         end else begin
            do_pop  = rd && (mq.size() > 0);
            do_push = v && ((mq.size() < D) || do_pop);
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({inst, pc});
         end
      end
      #1;
   endtask

   task automatic idle_edge();
      drive_edge(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic check_model(input string tag);
      logic [31:0] ei;
      logic [31:0] ep;
      ei = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
      ep = (mq.size() != 0) ? mq[0][31:0]  : 32'h0;
      chk({tag, ".valid"}, 64'(ID_inst_valid), 64'(mq.size() != 0));
      chk({tag, ".inst"},  64'(ID_inst), 64'(ei));
      chk({tag, ".pc"},    64'(ID_pc), 64'(ep));
      chk({tag, ".full"},  64'(IF_queue_is_full), 64'(mq.size() >= D - 2));
      chk({tag, ".count"}, 64'(dut.count_q), 64'(mq.size()));
   endtask

   typedef struct {
      logic        r;
      logic        v;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        rd;
      logic        cl;
      logic        ev;
      logic [31:0] einst;
      logic [31:0] epc;
      logic        ef;
      int          ecnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int cyc;
      int pushed;
      logic [31:0] pc_hold;

      tbl[0]  = '{1'b1, 1'b1, 32'h00000013, 32'h000, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h000, 1'b0, 1};
      tbl[1]  = '{1'b1, 1'b1, 32'h00100093, 32'h004, 1'b0, 1'b0, 1'b1, 32'h00000013, 32'h000, 1'b0, 2};
      tbl[2]  = '{1'b1, 1'b0, 32'h0,        32'h000, 1'b1, 1'b0, 1'b1, 32'h00100093, 32'h004, 1'b0, 1};
      tbl[3]  = '{1'b1, 1'b0, 32'h0,        32'h000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h000, 1'b0, 0};
      tbl[4]  = '{1'b0, 1'b1, 32'h000000aa, 32'h008, 1'b1, 1'b1, 1'b0, 32'h0,        32'h000, 1'b0, 0};
      tbl[5]  = '{1'b1, 1'b1, 32'h00000073, 32'h100, 1'b0, 1'b0, 1'b1, 32'h00000073, 32'h100, 1'b0, 1};
      tbl[6]  = '{1'b0, 1'b0, 32'h0,        32'h000, 1'b1, 1'b1, 1'b1, 32'h00000073, 32'h100, 1'b0, 1};
      tbl[7]  = '{1'b1, 1'b1, 32'h00000001, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0,        32'h000, 1'b0, 0};
      tbl[8]  = '{1'b1, 1'b1, 32'h00000002, 32'h300, 1'b1, 1'b0, 1'b1, 32'h00000002, 32'h300, 1'b0, 1};
      tbl[9]  = '{1'b1, 1'b1, 32'h00000003, 32'h304, 1'b1, 1'b0, 1'b1, 32'h00000003, 32'h304, 1'b0, 1};
      tbl[10] = '{1'b1, 1'b0, 32'h0,        32'h000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h000, 1'b0, 0};

      rst = 1'b1; rdy = 1'b0; IF_inst_valid = 1'b0; IF_inst = '0; IF_pc = '0;
      ID_ready = 1'b0; ROB_clear = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("reset.valid", 64'(ID_inst_valid), 64'(0));
      chk("reset.pc",    64'(ID_pc), 64'(0));
      chk("reset.inst",  64'(ID_inst), 64'(0));
      chk("reset.full",  64'(IF_queue_is_full), 64'(0));
      chk("reset.count", 64'(dut.count_q), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Vector table: ordering, rdy hold, flush priority, push+pop at one.
      for (int i = 0; i < 11; i++) begin
         drive_edge(tbl[i].r, tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].rd, tbl[i].cl);
         chk($sformatf("vec%0d.valid", i), 64'(ID_inst_valid), 64'(tbl[i].ev));
         chk($sformatf("vec%0d.inst", i),  64'(ID_inst), 64'(tbl[i].einst));
         chk($sformatf("vec%0d.pc", i),    64'(ID_pc), 64'(tbl[i].epc));
         chk($sformatf("vec%0d.full", i),  64'(IF_queue_is_full), 64'(tbl[i].ef));
         chk($sformatf("vec%0d.count", i), 64'(dut.count_q), 64'(tbl[i].ecnt));
      end

      // Fill with decode stalled; full flag at 14, 17th push dropped.
      for (int i = 0; i < 17; i++) begin
         drive_edge(1'b1, 1'b1, 32'hA000_0000 + 32'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
         if (i == 12) chk("fill.full_at13", 64'(IF_queue_is_full), 64'(0));
         if (i == 13) chk("fill.full_at14", 64'(IF_queue_is_full), 64'(1));
         check_model($sformatf("fill%0d", i));
      end
      chk("fill.sat_count", 64'(dut.count_q), 64'(16));
      chk("fill.head_pc",   64'(ID_pc), 64'(32'h1000));

      // Push and pop together while full.
      drive_edge(1'b1, 1'b1, 32'hBEEF_0001, 32'h2000, 1'b1, 1'b0);
      chk("fullpp.count", 64'(dut.count_q), 64'(16));
      chk("fullpp.head",  64'(ID_pc), 64'(32'h1004));
      check_model("fullpp");

      popped.delete();
      for (int i = 0; i < 16; i++) drive_edge(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drain.n", 64'(popped.size()), 64'(16));
      for (int i = 0; i < 16 && i < popped.size(); i++)
         chk($sformatf("drain%0d", i), 64'(popped[i]),
             64'((i < 15) ? 32'h1004 + 32'(4 * i) : 32'h2000));
      check_model("drained");

      // Flush with a concurrent push, then a push after the flush.
      for (int i = 0; i < 5; i++) drive_edge(1'b1, 1'b1, 32'h5, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      chk("flush.pre", 64'(dut.count_q), 64'(5));
      drive_edge(1'b1, 1'b1, 32'h77, 32'h80, 1'b0, 1'b1);
      chk("flush.count", 64'(dut.count_q), 64'(0));
      chk("flush.valid", 64'(ID_inst_valid), 64'(0));
      drive_edge(1'b1, 1'b1, 32'h99, 32'h100, 1'b0, 1'b0);
      chk("flush.newpc", 64'(ID_pc), 64'(32'h100));
      check_model("flush");
      drive_edge(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Wrap stress: 40 in-order pushes drained at a random ready pattern.
      popped.delete();
      pushed = 0;
      cyc = 0;
      while ((popped.size() < 40) && (cyc < 2000)) begin
         if ((pushed < 40) && (mq.size() < D - 2)) begin
            drive_edge(1'b1, 1'b1, 32'h13, 32'(4 * pushed), 1'($urandom_range(0, 2) == 0), 1'b0);
            pushed++;
         end else begin
            drive_edge(1'b1, 1'b0, 32'h0, 32'h0, 1'($urandom_range(0, 2) == 0), 1'b0);
         end
         cyc++;
      end
      chk("wrap.n", 64'(popped.size()), 64'(40));
      for (int i = 0; i < 40 && i < popped.size(); i++)
         chk($sformatf("wrap%0d", i), 64'(popped[i]), 64'(4 * i));
      check_model("wrap.end");

      // rdy low for 4 cycles during push/pop/clear activity.
      for (int i = 0; i < 3; i++) drive_edge(1'b1, 1'b1, 32'h11, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      pc_hold = ID_pc;
      for (int i = 0; i < 4; i++) begin
         drive_edge(1'b0, 1'b1, 32'h22, 32'h600, 1'b1, 1'(i == 2));
         chk($sformatf("hold%0d.count", i), 64'(dut.count_q), 64'(3));
         chk($sformatf("hold%0d.pc", i), 64'(ID_pc), 64'(pc_hold));
      end
      check_model("hold");

      // Asynchronous reset between edges with 3 entries queued.
      #2 rst = 1'b0;
      #1;
      mq.delete();
      chk("arst.valid", 64'(ID_inst_valid), 64'(0));
      chk("arst.pc",    64'(ID_pc), 64'(0));
      chk("arst.full",  64'(IF_queue_is_full), 64'(0));
      chk("arst.count", 64'(dut.count_q), 64'(0));
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive_edge(1'b1, 1'b1, 32'h33, 32'h700, 1'b0, 1'b0);
      chk("arst.firstpush", 64'(ID_pc), 64'(32'h700));
      check_model("arst.after");

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         drive_edge(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 39) == 0));
         check_model($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
